// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain loader.
// Holds the FSM state encoding, the CRC-8 parameters and the common counter widths.
package ccff_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } ccff_state_e;

  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BITS_W = 4;

endpackage

// File: rtl/ccff_loader_if.sv
// Byte-stream handshake into the loader: producer drives data/valid, loader drives ready.
interface ccff_loader_if;
  import ccff_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/ccff_crc8.sv
// Serial MSB-first CRC-8 accumulator; clear wins over enable.
module ccff_crc8
  import ccff_pkg::*;
(
  input  logic       prog_clk,
  input  logic       reset_n,
  input  logic       bit_in,
  input  logic       enable,
  input  logic       clear,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic       fb_c;

  // One LFSR step per enabled bit.
  always_comb begin
    crc_d = crc_q;
    fb_c  = crc_q[7] ^ bit_in;
    if (clear) begin
      crc_d = CRC_INIT;
    end else if (enable) begin
      crc_d = {crc_q[6:0], 1'b0} ^ (fb_c ? CRC_POLY : 8'h00);
    end
  end

  always_ff @(posedge prog_clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ccff_loader.sv
// Streams a byte-wide bitstream MSB-first into a configuration flop chain,
// then checks a trailing CRC-8 byte against the bits actually shifted.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64
) (
  input  logic              prog_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              cfg_shift,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);

  ccff_state_e       state_q, state_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [BITS_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              head_q, head_d;
  logic              shift_q, shift_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              crc_clear_c;
  logic              accept_c;
  logic [7:0]        crc;

  // Ready when the byte register is empty or on its last bit, but never for
  // a data byte once every remaining chain position is already spoken for.
  function automatic logic ready_f(input ccff_state_e st,
                                   input logic [BITS_W-1:0] bits,
                                   input logic [CNT_W-1:0] cnt);
    logic r;
    r = 1'b0;
    case (st)
      LOAD:  r = (cnt != LEN) &&
                 ((bits == BITS_W'(0)) ||
                  ((bits == BITS_W'(1)) && ((LEN - cnt) > CNT_W'(1))));
      CHECK: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign accept_c = in_valid && ready_q && !abort;

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    bits_d      = bits_q;
    cnt_d       = cnt_q;
    head_d      = head_q;
    shift_d     = 1'b0;
    crc_clear_c = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d     = LOAD;
          byte_d      = '0;
          bits_d      = '0;
          cnt_d       = '0;
          crc_clear_c = 1'b1;
        end
      end

      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          // Drain the held byte first; a new byte refills behind its last bit.
          if (bits_q != BITS_W'(0)) begin
            head_d  = byte_q[BYTE_W-1];
            shift_d = 1'b1;
            if (accept_c) begin
              byte_d = in_data;
              bits_d = BITS_W'(BYTE_W);
            end else begin
              byte_d = {byte_q[BYTE_W-2:0], 1'b0};
              bits_d = bits_q - BITS_W'(1);
            end
          end else if (accept_c) begin
            head_d  = in_data[BYTE_W-1];
            shift_d = 1'b1;
            byte_d  = {in_data[BYTE_W-2:0], 1'b0};
            bits_d  = BITS_W'(BYTE_W - 1);
          end

          // Final chain bit issued: leftover low-order bits are dropped.
          if (shift_d) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == LEN) begin
              bits_d = '0;
            end
          end

          if (cnt_q == LEN) begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept_c) begin
          state_d = (in_data == crc) ? DONE : ERROR;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == LOAD) || (state_d == CHECK);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
    ready_d = ready_f(state_d, bits_d, cnt_d);
  end

  always_ff @(posedge prog_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      byte_q  <= '0;
      bits_q  <= '0;
      cnt_q   <= '0;
      head_q  <= 1'b0;
      shift_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // CRC sees exactly the bits the chain captures.
  ccff_crc8 u_crc (
    .prog_clk (prog_clk),
    .reset_n  (reset_n),
    .bit_in   (head_q),
    .enable   (shift_q),
    .clear    (crc_clear_c),
    .crc      (crc)
  );

  assign in_ready  = ready_q;
  assign ccff_head = head_q;
  assign cfg_shift = shift_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
